mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- State register and control-signal decoder for the multi-cycle MIPS core.
- Holds the current FSM state and the opcode latched at fetch, and feeds both to the next-state logic.
- Registers the next-state value it receives back, with memory-wait stalls and illegal-opcode trapping.
- Decodes (state, opcode) into all datapath strobes/selects and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset: asynchronous, active-low (rst==0 resets)
new_state  in  STATE_LEN  next state from next-state logic
opcode_in  in  6  instr[31:26] from instruction memory read data
mem_ready  in  1  memory access completes this cycle
state  out  STATE_LEN  current state register (to next-state logic)
opcode  out  6  latched opcode (to next-state logic)
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (beq)
ir_write  out  1  instruction register load
i_or_d  out  1  memory address select: 0=PC, 1=ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
reg_write  out  1  register file write
reg_dst  out  1  1=rd, 0=rt
mem_to_reg  out  1  1=MDR, 0=ALUOut
alu_src_a  out  1  0=PC, 1=A
alu_src_b  out  2  00=B, 01=const 4, 10=ext imm, 11=ext imm<<2
alu_op  out  2  00=add, 01=sub, 10=funct, 11=or
pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
ext_zero  out  1  zero-extend immediate (ori)
illegal  out  1  sticky illegal-opcode flag
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset (rst==0, async): state=STATE_IF, opcode=6'b0, illegal=0, instr_count=0. All strobes (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) are forced 0 while rst==0.
- Decoded outputs are combinational from registered state and opcode. Outputs not listed for a state/opcode are 0.
- Stall: state holds when state==IF and !mem_ready, or state==MEM, opcode in {LW,SW} and !mem_ready. Otherwise state<=new_state each rising edge.
- Illegal-opcode trap: in ID, an opcode not in {R,J,BEQ,ADDI,ORI,LW,SW} overrides new_state with next state=IF and sets illegal=1. illegal stays set until reset. Execution continues with the next instruction.
- Opcode latch: opcode<=opcode_in on the edge ending IF with mem_ready=1, the same edge as ir_write.
- IF: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. pc_write=mem_ready, ir_write=mem_ready. The PC does not advance during a stall.
- ID: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target). For J: pc_write=1, pc_src=10.
- EX, by opcode:
  - R: src_a=1, src_b=00, alu_op=10.
  - ADDI/LW/SW: src_a=1, src_b=10, alu_op=00.
  - ORI: src_a=1, src_b=10, alu_op=11, ext_zero=1.
  - BEQ: src_a=1, src_b=00, alu_op=01, pc_write_cond=1, pc_src=01.
- MEM: i_or_d=1. LW: mem_read=1. SW: mem_write=1, held through stall cycles.
- WB:
  - R: reg_write=1, reg_dst=1, mem_to_reg=0.
  - ADDI/ORI: reg_write=1, reg_dst=0.
  - LW: reg_write=1, reg_dst=0, mem_to_reg=1.
- Retire: instr_count increments by 1 on any edge where state!=IF, the applied next state is IF, and no stall applies. Trapped illegal opcodes do not count. Wraps from all-ones to 0.
- Unknown state encoding: treated as IF for decode; next state forced to IF.
- Reset mid-instruction: immediate return to reset values. Any in-progress store is dropped (mem_write=0 asynchronously).

Decomposition:
- Shared defines.v holds STATE_LEN=3, STATE_IF=0, ID=1, EX=2, MEM=3, WB=4.
- Shared defines.v holds OP_R_TYPE=000000, OP_J=000010, OP_BEQ=000100, OP_ADDI=001000, OP_ORI=001101, OP_LW=100011, OP_SW=101011.
- Shared defines.v holds the ALU_OP and PC_SRC encodings above.
- One sub-module: mc_ctrl_decode, purely combinational (state, opcode -> strobes/selects). The top level owns the state/opcode/illegal/counter registers and stall logic.

Test Plan:
- Reset release, mem_ready=1, opcode_in=LW: states IF,ID,EX,MEM,WB,IF. mem_read in IF and MEM, reg_write+mem_to_reg in WB, instr_count=1.
- IF with mem_ready=0 for 3 cycles: state stays IF, pc_write=0, ir_write=0, mem_read=1. On mem_ready=1, pc_write=ir_write=1 and state goes to ID next edge.
- SW with mem_ready=0 for 2 cycles in MEM: mem_write=1 for 3 cycles, then IF. instr_count increments exactly once.
- J: IF,ID,IF. In ID pc_write=1, pc_src=10. BEQ: EX has pc_write_cond=1, alu_op=01, pc_src=01, then IF.
- opcode_in=6'b111111: ID then IF, illegal=1 sticky, instr_count unchanged. A following ADDI completes in 4 states with ext_zero=0. ORI sets ext_zero=1 in EX.
- rst asserted during MEM of SW: mem_write drops to 0 without a clock, state=IF, counter=0. Also preload count to all-ones and retire one R-type -> 0.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit:
// FSM states, opcodes, ALU/PC select codes and the decoded control bundle.
package mc_control_unit_pkg;

    localparam int STATE_LEN = 3;

    localparam logic [STATE_LEN-1:0] STATE_IF  = 3'd0;
    localparam logic [STATE_LEN-1:0] STATE_ID  = 3'd1;
    localparam logic [STATE_LEN-1:0] STATE_EX  = 3'd2;
    localparam logic [STATE_LEN-1:0] STATE_MEM = 3'd3;
    localparam logic [STATE_LEN-1:0] STATE_WB  = 3'd4;

    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OP_OR    = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       ext_zero;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        return (op == OP_R_TYPE) || (op == OP_J) || (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_ORI) || (op == OP_LW) ||
               (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Bundle between the control unit, next-state logic, memory and datapath.
// slave = control unit side, master = environment side.
interface mc_control_unit_if
    import mc_control_unit_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic [STATE_LEN-1:0] new_state;
    logic [5:0]           opcode_in;
    logic                 mem_ready;
    logic [STATE_LEN-1:0] state;
    logic [5:0]           opcode;
    logic                 pc_write;
    logic                 pc_write_cond;
    logic                 ir_write;
    logic                 i_or_d;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic                 reg_dst;
    logic                 mem_to_reg;
    logic                 alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           alu_op;
    logic [1:0]           pc_src;
    logic                 ext_zero;
    logic                 illegal;
    logic [CNT_W-1:0]     instr_count;

    modport slave (
        input  new_state, opcode_in, mem_ready,
        output state, opcode, pc_write, pc_write_cond, ir_write,
        output i_or_d, mem_read, mem_write, reg_write, reg_dst,
        output mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
        output ext_zero, illegal, instr_count
    );

    modport master (
        output new_state, opcode_in, mem_ready,
        input  state, opcode, pc_write, pc_write_cond, ir_write,
        input  i_or_d, mem_read, mem_write, reg_write, reg_dst,
        input  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src,
        input  ext_zero, illegal, instr_count
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational (state, opcode) -> datapath strobes/selects.
// Any state encoding outside IF..WB decodes as IF.
module mc_ctrl_decode
    import mc_control_unit_pkg::*;
(
    input  logic [STATE_LEN-1:0] state,
    input  logic [5:0]           opcode,
    input  logic                 mem_ready,
    output ctrl_t                ctrl
);
    logic is_if, is_id, is_ex, is_mem, is_wb;

    always_comb begin
        is_id  = (state == STATE_ID);
        is_ex  = (state == STATE_EX);
        is_mem = (state == STATE_MEM);
        is_wb  = (state == STATE_WB);
        is_if  = !(is_id || is_ex || is_mem || is_wb);
        ctrl   = '0;
        unique case (1'b1)
            is_if: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.pc_write  = mem_ready;
                ctrl.ir_write  = mem_ready;
            end
            is_id: begin
                ctrl.alu_src_b = SRC_B_IMMSH;
                if (opcode == OP_J) begin
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_SRC_JUMP;
                end
            end
            is_ex: begin
                case (opcode)
                    OP_R_TYPE: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_op    = ALU_OP_FUNCT;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRC_B_IMM;
                    end
                    OP_ORI: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRC_B_IMM;
                        ctrl.alu_op    = ALU_OP_OR;
                        ctrl.ext_zero  = 1'b1;
                    end
                    OP_BEQ: begin
                        ctrl.alu_src_a     = 1'b1;
                        ctrl.alu_op        = ALU_OP_SUB;
                        ctrl.pc_write_cond = 1'b1;
                        ctrl.pc_src        = PC_SRC_ALUOUT;
                    end
                    default: ;
                endcase
            end
            is_mem: begin
                ctrl.i_or_d    = 1'b1;
                ctrl.mem_read  = (opcode == OP_LW);
                ctrl.mem_write = (opcode == OP_SW);
            end
            is_wb: begin
                case (opcode)
                    OP_R_TYPE: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = 1'b1;
                    end
                    OP_ADDI, OP_ORI: ctrl.reg_write = 1'b1;
                    OP_LW: begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.mem_to_reg = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS control unit: state/opcode registers, memory stalls,
// illegal-opcode trap, retired-instruction counter and output decode.
module mc_control_unit
    import mc_control_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    mc_control_unit_if.slave bus
);
    logic [STATE_LEN-1:0] state_q, state_d, next_st;
    logic [5:0]           opcode_q, opcode_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_W-1:0]     instr_count_q, instr_count_d;
    logic                 is_ls, stall, trap, retire;
    ctrl_t                ctrl;

    mc_ctrl_decode u_decode (
        .state     (state_q),
        .opcode    (opcode_q),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    always_comb begin
        is_ls = (opcode_q == OP_LW) || (opcode_q == OP_SW);
        stall = ((state_q == STATE_IF) && !bus.mem_ready) ||
                ((state_q == STATE_MEM) && is_ls && !bus.mem_ready);
        trap  = (state_q == STATE_ID) && !op_legal(opcode_q);
        next_st = bus.new_state;
        if (trap || (state_q > STATE_WB))
            next_st = STATE_IF;
        state_d  = stall ? state_q : next_st;
        opcode_d = ctrl.ir_write ? bus.opcode_in : opcode_q;
        illegal_d = illegal_q | trap;
        // trapped opcodes return to IF but are not retired
        retire = (state_q != STATE_IF) && (next_st == STATE_IF) &&
                 !stall && !trap;
        instr_count_d = instr_count_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= STATE_IF;
            opcode_q      <= 6'b0;
            illegal_q     <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            illegal_q     <= illegal_d;
            instr_count_q <= instr_count_d;
        end
    end

    // strobes are gated by reset so an in-flight store drops immediately
    assign bus.pc_write      = ctrl.pc_write & rst;
    assign bus.pc_write_cond = ctrl.pc_write_cond & rst;
    assign bus.ir_write      = ctrl.ir_write & rst;
    assign bus.mem_read      = ctrl.mem_read & rst;
    assign bus.mem_write     = ctrl.mem_write & rst;
    assign bus.reg_write     = ctrl.reg_write & rst;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.pc_src        = ctrl.pc_src;
    assign bus.ext_zero      = ctrl.ext_zero;
    assign bus.state         = state_q;
    assign bus.opcode        = opcode_q;
    assign bus.illegal       = illegal_q;
    assign bus.instr_count   = instr_count_q;
endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit; counter narrowed to 4 bits
// so the wrap from all-ones to zero is reachable.
module tb_mc_control_unit;
    import mc_control_unit_pkg::*;

    localparam int CW = 4;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    mc_control_unit_if #(.CNT_W(CW)) bus ();

    mc_control_unit #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input logic [2:0] ns, input logic rdy);
        bus.new_state = ns;
        bus.mem_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.state !== STATE_IF) begin
            n_fail++;
            $display("FAIL rst_state got %0d exp 0", bus.state);
        end
        n_tests++;
        if (bus.instr_count !== 4'd0 || bus.illegal !== 1'b0 || bus.opcode !== 6'd0) begin
            n_fail++;
            $display("FAIL rst_regs got cnt=%0d ill=%0b op=%0h exp 0/0/0",
                     bus.instr_count, bus.illegal, bus.opcode);
        end
        n_tests++;
        if (bus.pc_write !== 1'b0 || bus.ir_write !== 1'b0 || bus.mem_read !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_strobes got pcw=%0b irw=%0b mr=%0b exp 0",
                     bus.pc_write, bus.ir_write, bus.mem_read);
        end
    endtask

    task automatic test_lw();
        bus.opcode_in = OP_LW;
        bus.mem_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.mem_read !== 1'b1 || bus.pc_write !== 1'b1 || bus.ir_write !== 1'b1 ||
            bus.alu_src_b !== 2'b01 || bus.i_or_d !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_if got mr=%0b pcw=%0b irw=%0b sb=%0d iod=%0b exp 1/1/1/1/0",
                     bus.mem_read, bus.pc_write, bus.ir_write, bus.alu_src_b, bus.i_or_d);
        end
        cyc(STATE_ID, 1'b1);
        n_tests++;
        if (bus.state !== STATE_ID || bus.opcode !== OP_LW || bus.alu_src_b !== 2'b11) begin
            n_fail++;
            $display("FAIL lw_id got st=%0d op=%0h sb=%0d exp 1/23/3",
                     bus.state, bus.opcode, bus.alu_src_b);
        end
        cyc(STATE_EX, 1'b1);
        n_tests++;
        if (bus.state !== STATE_EX || bus.alu_src_a !== 1'b1 ||
            bus.alu_src_b !== 2'b10 || bus.alu_op !== 2'b00) begin
            n_fail++;
            $display("FAIL lw_ex got st=%0d sa=%0b sb=%0d op=%0d exp 2/1/2/0",
                     bus.state, bus.alu_src_a, bus.alu_src_b, bus.alu_op);
        end
        cyc(STATE_MEM, 1'b1);
        n_tests++;
        if (bus.state !== STATE_MEM || bus.mem_read !== 1'b1 ||
            bus.i_or_d !== 1'b1 || bus.mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_mem got st=%0d mr=%0b iod=%0b mw=%0b exp 3/1/1/0",
                     bus.state, bus.mem_read, bus.i_or_d, bus.mem_write);
        end
        cyc(STATE_WB, 1'b1);
        n_tests++;
        if (bus.state !== STATE_WB || bus.reg_write !== 1'b1 ||
            bus.mem_to_reg !== 1'b1 || bus.reg_dst !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_wb got st=%0d rw=%0b m2r=%0b rd=%0b exp 4/1/1/0",
                     bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst);
        end
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.state !== STATE_IF || bus.instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL lw_retire got st=%0d cnt=%0d exp 0/1", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_if_stall();
        bus.opcode_in = OP_SW;
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = 1'b0;
            #1;
            n_tests++;
            if (bus.state !== STATE_IF || bus.pc_write !== 1'b0 ||
                bus.ir_write !== 1'b0 || bus.mem_read !== 1'b1) begin
                n_fail++;
                $display("FAIL if_stall%0d got st=%0d pcw=%0b irw=%0b mr=%0b exp 0/0/0/1",
                         i, bus.state, bus.pc_write, bus.ir_write, bus.mem_read);
            end
            cyc(STATE_ID, 1'b0);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_tests++;
        if (bus.state !== STATE_IF || bus.pc_write !== 1'b1 || bus.ir_write !== 1'b1) begin
            n_fail++;
            $display("FAIL if_ready got st=%0d pcw=%0b irw=%0b exp 0/1/1",
                     bus.state, bus.pc_write, bus.ir_write);
        end
        cyc(STATE_ID, 1'b1);
        n_tests++;
        if (bus.state !== STATE_ID || bus.opcode !== OP_SW) begin
            n_fail++;
            $display("FAIL if_to_id got st=%0d op=%0h exp 1/2b", bus.state, bus.opcode);
        end
    endtask

    task automatic test_sw_stall();
        cyc(STATE_EX, 1'b1);
        cyc(STATE_MEM, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.mem_ready = (i == 2);
            #1;
            n_tests++;
            if (bus.state !== STATE_MEM || bus.mem_write !== 1'b1 ||
                bus.instr_count !== 4'd1) begin
                n_fail++;
                $display("FAIL sw_mem%0d got st=%0d mw=%0b cnt=%0d exp 3/1/1",
                         i, bus.state, bus.mem_write, bus.instr_count);
            end
            cyc(STATE_IF, i == 2);
        end
        n_tests++;
        if (bus.state !== STATE_IF || bus.mem_write !== 1'b0 || bus.instr_count !== 4'd2) begin
            n_fail++;
            $display("FAIL sw_retire got st=%0d mw=%0b cnt=%0d exp 0/0/2",
                     bus.state, bus.mem_write, bus.instr_count);
        end
    endtask

    task automatic test_jump_beq();
        bus.opcode_in = OP_J;
        cyc(STATE_ID, 1'b1);
        n_tests++;
        if (bus.pc_write !== 1'b1 || bus.pc_src !== 2'b10) begin
            n_fail++;
            $display("FAIL j_id got pcw=%0b pcs=%0d exp 1/2", bus.pc_write, bus.pc_src);
        end
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.state !== STATE_IF || bus.instr_count !== 4'd3) begin
            n_fail++;
            $display("FAIL j_retire got st=%0d cnt=%0d exp 0/3", bus.state, bus.instr_count);
        end
        bus.opcode_in = OP_BEQ;
        cyc(STATE_ID, 1'b1);
        cyc(STATE_EX, 1'b1);
        n_tests++;
        if (bus.pc_write_cond !== 1'b1 || bus.alu_op !== 2'b01 ||
            bus.pc_src !== 2'b01 || bus.pc_write !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_ex got pwc=%0b op=%0d pcs=%0d pcw=%0b exp 1/1/1/0",
                     bus.pc_write_cond, bus.alu_op, bus.pc_src, bus.pc_write);
        end
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.state !== STATE_IF || bus.instr_count !== 4'd4) begin
            n_fail++;
            $display("FAIL beq_retire got st=%0d cnt=%0d exp 0/4", bus.state, bus.instr_count);
        end
    endtask

    task automatic test_illegal();
        bus.opcode_in = 6'b111111;
        cyc(STATE_ID, 1'b1);
        n_tests++;
        if (bus.state !== STATE_ID || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_id got st=%0d ill=%0b exp 1/0", bus.state, bus.illegal);
        end
        cyc(STATE_EX, 1'b1);
        n_tests++;
        if (bus.state !== STATE_IF || bus.illegal !== 1'b1 || bus.instr_count !== 4'd4) begin
            n_fail++;
            $display("FAIL ill_trap got st=%0d ill=%0b cnt=%0d exp 0/1/4",
                     bus.state, bus.illegal, bus.instr_count);
        end
        bus.opcode_in = OP_ADDI;
        cyc(STATE_ID, 1'b1);
        cyc(STATE_EX, 1'b1);
        n_tests++;
        if (bus.ext_zero !== 1'b0 || bus.alu_op !== 2'b00 || bus.alu_src_b !== 2'b10) begin
            n_fail++;
            $display("FAIL addi_ex got ez=%0b op=%0d sb=%0d exp 0/0/2",
                     bus.ext_zero, bus.alu_op, bus.alu_src_b);
        end
        cyc(STATE_WB, 1'b1);
        n_tests++;
        if (bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
            n_fail++;
            $display("FAIL addi_wb got rw=%0b rd=%0b m2r=%0b exp 1/0/0",
                     bus.reg_write, bus.reg_dst, bus.mem_to_reg);
        end
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.instr_count !== 4'd5 || bus.illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL addi_retire got cnt=%0d ill=%0b exp 5/1",
                     bus.instr_count, bus.illegal);
        end
        bus.opcode_in = OP_ORI;
        cyc(STATE_ID, 1'b1);
        cyc(STATE_EX, 1'b1);
        n_tests++;
        if (bus.ext_zero !== 1'b1 || bus.alu_op !== 2'b11) begin
            n_fail++;
            $display("FAIL ori_ex got ez=%0b op=%0d exp 1/3", bus.ext_zero, bus.alu_op);
        end
        cyc(STATE_WB, 1'b1);
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.instr_count !== 4'd6) begin
            n_fail++;
            $display("FAIL ori_retire got cnt=%0d exp 6", bus.instr_count);
        end
    endtask

    task automatic test_wrap();
        bus.opcode_in = OP_R_TYPE;
        for (int i = 0; i < 10; i++) begin
            cyc(STATE_ID, 1'b1);
            cyc(STATE_EX, 1'b1);
            if (i == 0) begin
                n_tests++;
                if (bus.alu_op !== 2'b10 || bus.alu_src_b !== 2'b00 || bus.alu_src_a !== 1'b1) begin
                    n_fail++;
                    $display("FAIL r_ex got op=%0d sb=%0d sa=%0b exp 2/0/1",
                             bus.alu_op, bus.alu_src_b, bus.alu_src_a);
                end
            end
            cyc(STATE_WB, 1'b1);
            if (i == 0) begin
                n_tests++;
                if (bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
                    n_fail++;
                    $display("FAIL r_wb got rw=%0b rd=%0b m2r=%0b exp 1/1/0",
                             bus.reg_write, bus.reg_dst, bus.mem_to_reg);
                end
            end
            cyc(STATE_IF, 1'b1);
            if (i == 8) begin
                n_tests++;
                if (bus.instr_count !== 4'd15) begin
                    n_fail++;
                    $display("FAIL cnt_max got %0d exp 15", bus.instr_count);
                end
            end
        end
        n_tests++;
        if (bus.instr_count !== 4'd0) begin
            n_fail++;
            $display("FAIL cnt_wrap got %0d exp 0", bus.instr_count);
        end
    endtask

    task automatic test_reset_mid_sw();
        bus.opcode_in = OP_SW;
        cyc(STATE_ID, 1'b1);
        cyc(STATE_EX, 1'b1);
        cyc(STATE_IF, 1'b1);
        n_tests++;
        if (bus.instr_count !== 4'd1) begin
            n_fail++;
            $display("FAIL pre_rst_cnt got %0d exp 1", bus.instr_count);
        end
        bus.opcode_in = OP_SW;
        cyc(STATE_ID, 1'b1);
        cyc(STATE_EX, 1'b1);
        cyc(STATE_MEM, 1'b1);
        bus.mem_ready = 1'b0;
        #1;
        n_tests++;
        if (bus.state !== STATE_MEM || bus.mem_write !== 1'b1) begin
            n_fail++;
            $display("FAIL sw2_mem got st=%0d mw=%0b exp 3/1", bus.state, bus.mem_write);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.mem_write !== 1'b0 || bus.state !== STATE_IF ||
            bus.instr_count !== 4'd0 || bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_rst got mw=%0b st=%0d cnt=%0d ill=%0b exp 0/0/0/0",
                     bus.mem_write, bus.state, bus.instr_count, bus.illegal);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b0;
        bus.new_state = STATE_IF;
        bus.opcode_in = OP_LW;
        bus.mem_ready = 1'b1;
        #3;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        test_lw();
        test_if_stall();
        test_sw_stall();
        test_jump_beq();
        test_illegal();
        test_wrap();
        test_reset_mid_sw();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
